// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with relative branch, absolute jump, and call/return
// through a hardware return-address stack. Priority is ret > call > jump > branch > inc.
module pc_sequencer #(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pc_en,
  input  logic                               branch,
  input  logic [ADDR_W-1:0]                  branch_off,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_W-1:0]                  target_addr,
  input  logic                               err_clr,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   ras_count,
  output logic                               ras_full,
  output logic                               ras_empty,
  output logic                               stack_err
);

  localparam int unsigned    CW         = $clog2(STACK_DEPTH + 1);
  localparam int unsigned    IW         = $clog2(STACK_DEPTH);
  localparam logic [CW-1:0]  FULL_COUNT = CW'(STACK_DEPTH);
  localparam logic [CW-1:0]  ONE_COUNT  = CW'(1);

  logic [ADDR_W-1:0] ras_mem [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_branch;
  logic [ADDR_W-1:0] ras_top;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     push_idx;
  logic              do_pop;
  logic              do_push;
  logic              underflow;
  logic              overflow;

  assign ras_full  = (ras_count == FULL_COUNT);
  assign ras_empty = (ras_count == '0);

  // Adds wrap modulo 2^ADDR_W; the offset is two's complement so a plain add suffices.
  always_comb begin
    pc_inc    = pc + ADDR_W'(1);
    pc_branch = pc + branch_off;
    top_idx   = IW'(ras_count - ONE_COUNT);
    push_idx  = IW'(ras_count);
    ras_top   = ras_mem[top_idx];
    underflow = pc_en & ret & ras_empty;
    overflow  = pc_en & ~ret & call & ras_full;
    do_pop    = pc_en & ret & ~ras_empty;
    do_push   = pc_en & ~ret & call & ~ras_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      ras_count <= '0;
      stack_err <= 1'b0;
    end else begin
      if (pc_en) begin
        if (ret) begin
          pc <= ras_empty ? pc_inc : ras_top;
        end else if (call) begin
          pc <= ras_full ? pc_inc : target_addr;
        end else if (jump) begin
          pc <= target_addr;
        end else if (branch) begin
          pc <= pc_branch;
        end else begin
          pc <= pc_inc;
        end
      end
      if (do_pop) begin
        ras_count <= ras_count - ONE_COUNT;
      end else if (do_push) begin
        ras_count <= ras_count + ONE_COUNT;
      end
      // A fresh error outranks a clear requested in the same cycle.
      stack_err <= underflow | overflow | (stack_err & ~err_clr);
    end
  end

  // Stack storage carries no reset; entries at or above ras_count are never read.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      ras_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random commands, each cycle
// checked against a queue-based model of the program counter and return stack.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        pc_en;
  logic        branch;
  logic [15:0] branch_off;
  logic        jump;
  logic        call;
  logic        ret;
  logic [15:0] target_addr;
  logic        err_clr;
  logic [15:0] pc;
  logic [2:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic        stack_err;

  int total = 0;
  int bad   = 0;

  // Model state: expected pc, expected return stack (back = top), expected error flag.
  logic [15:0] exp_pc;
  logic [15:0] exp_q[$];
  logic        exp_err;

  pc_sequencer #(
    .ADDR_W(16),
    .STACK_DEPTH(DEPTH),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc_en(pc_en),
    .branch(branch),
    .branch_off(branch_off),
    .jump(jump),
    .call(call),
    .ret(ret),
    .target_addr(target_addr),
    .err_clr(err_clr),
    .pc(pc),
    .ras_count(ras_count),
    .ras_full(ras_full),
    .ras_empty(ras_empty),
    .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic new_err;
    new_err = 1'b0;
    if (reset) begin
      exp_pc = 16'h0000;
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      if (pc_en) begin
        if (ret) begin
          if (exp_q.size() > 0) exp_pc = exp_q.pop_back();
          else begin exp_pc = exp_pc + 16'd1; new_err = 1'b1; end
        end else if (call) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back(exp_pc + 16'd1);
            exp_pc = target_addr;
          end else begin
            exp_pc = exp_pc + 16'd1;
            new_err = 1'b1;
          end
        end else if (jump) begin
          exp_pc = target_addr;
        end else if (branch) begin
          exp_pc = exp_pc + branch_off;
        end else begin
          exp_pc = exp_pc + 16'd1;
        end
      end
      exp_err = new_err | (exp_err & ~err_clr);
    end
  endtask

  task automatic check_all();
    check("pc", 32'(pc), 32'(exp_pc));
    check("ras_count", 32'(ras_count), 32'(exp_q.size()));
    check("ras_full", 32'(ras_full), 32'(exp_q.size() == DEPTH));
    check("ras_empty", 32'(ras_empty), 32'(exp_q.size() == 0));
    check("stack_err", 32'(stack_err), 32'(exp_err));
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic step(input logic rst, input logic en, input logic r, input logic c,
                      input logic j, input logic b, input logic [15:0] off,
                      input logic [15:0] tgt, input logic clr);
    @(negedge clk);
    reset = rst; pc_en = en; ret = r; call = c; jump = j; branch = b;
    branch_off = off; target_addr = tgt; err_clr = clr;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic inc();
    step(0, 1, 0, 0, 0, 0, 16'h0, 16'h0, 0);
  endtask
  task automatic stall();
    step(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
  endtask
  task automatic do_jump(input logic [15:0] t);
    step(0, 1, 0, 0, 1, 0, 16'h0, t, 0);
  endtask
  task automatic do_call(input logic [15:0] t);
    step(0, 1, 0, 1, 0, 0, 16'h0, t, 0);
  endtask
  task automatic do_ret();
    step(0, 1, 1, 0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  initial begin
    exp_pc = 16'h0; exp_err = 1'b0;
    reset = 1'b1; pc_en = 0; ret = 0; call = 0; jump = 0; branch = 0;
    branch_off = '0; target_addr = '0; err_clr = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_empty", 32'(ras_empty), 32'h1);

    // Increment then stall
    for (int i = 1; i <= 5; i++) begin
      inc();
      check("inc_pc", 32'(pc), 32'(i));
    end
    for (int i = 0; i < 3; i++) begin
      stall();
      check("stall_pc", 32'(pc), 32'h5);
    end

    // Negative branch, jump to top, wrap
    do_jump(16'h0010);
    step(0, 1, 0, 0, 0, 1, 16'hFFF8, 16'h0, 0);
    check("branch_back", 32'(pc), 32'h0008);
    do_jump(16'hFFFF);
    check("jump_top", 32'(pc), 32'hFFFF);
    inc();
    check("wrap", 32'(pc), 32'h0000);

    // Single call / return
    do_jump(16'h0020);
    do_call(16'h0100);
    check("call_pc", 32'(pc), 32'h0100);
    check("call_cnt", 32'(ras_count), 32'h1);
    inc(); inc(); inc();
    do_ret();
    check("ret_pc", 32'(pc), 32'h0021);
    check("ret_empty", 32'(ras_empty), 32'h1);

    // Nested calls to overflow, then LIFO unwind
    do_call(16'h1000);
    do_call(16'h2000);
    do_call(16'h3000);
    do_call(16'h4000);
    check("full", 32'(ras_full), 32'h1);
    do_call(16'h5000);
    check("ovf_pc", 32'(pc), 32'h4001);
    check("ovf_err", 32'(stack_err), 32'h1);
    check("ovf_cnt", 32'(ras_count), 32'h4);
    do_ret(); check("lifo0", 32'(pc), 32'h3001);
    do_ret(); check("lifo1", 32'(pc), 32'h2001);
    do_ret(); check("lifo2", 32'(pc), 32'h1001);
    do_ret(); check("lifo3", 32'(pc), 32'h0022);

    // Underflow, clear while stalled, clear losing to new error, priority
    step(0, 1, 0, 0, 0, 0, 16'h0, 16'h0, 1);
    do_ret();
    check("udf_pc", 32'(pc), 32'h0024);
    check("udf_err", 32'(stack_err), 32'h1);
    step(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 1);
    check("clr_err", 32'(stack_err), 32'h0);
    check("clr_hold", 32'(pc), 32'h0024);
    step(0, 1, 1, 0, 0, 0, 16'h0, 16'h0, 1);
    check("err_wins", 32'(stack_err), 32'h1);
    do_call(16'h0500);
    step(0, 1, 1, 1, 1, 1, 16'h0040, 16'h0900, 0);
    check("prio_pc", 32'(pc), 32'h0026);
    check("prio_cnt", 32'(ras_count), 32'h0);
    step(0, 0, 0, 1, 0, 0, 16'h0, 16'h0777, 0);
    check("stall_call", 32'(pc), 32'h0026);

    // Reset mid-sequence with three entries and error set
    do_ret();
    do_call(16'h0A00); do_call(16'h0B00); do_call(16'h0C00);
    check("pre_rst_cnt", 32'(ras_count), 32'h3);
    step(1, 1, 0, 1, 0, 0, 16'h0, 16'h0D00, 0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_cnt", 32'(ras_count), 32'h0);
    check("rst_err", 32'(stack_err), 32'h0);

    // Random commands
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
